// File: rtl/riscv_mul32_seq.sv
// Sequential RV32M multiplier: four 16x16 partial products through one unsigned
// mult16 primitive, accumulated into 64 bits, then sign-corrected for writeback.

module mult16 #(
    parameter bit AB_SIGNED = 1'b0
) (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] q
);

    generate
        if (AB_SIGNED) begin : g_signed
            assign q = 32'($signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b}));
        end else begin : g_unsigned
            assign q = {16'd0, a} * {16'd0, b};
        end
    endgenerate

endmodule

module riscv_mul32_seq #(
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    // Two's-complement magnitude; 0x80000000 maps onto itself, which is exact as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_neg);
        return is_neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [1:0]  cnt_r, cnt_nxt_s;
    logic [63:0] acc_r, acc_nxt_s;
    logic [31:0] a_mag_r, a_mag_nxt_s;
    logic [31:0] b_mag_r, b_mag_nxt_s;
    logic        neg_r, neg_nxt_s;
    logic [1:0]  op_r, op_nxt_s;
    logic [31:0] result_r, result_nxt_s;
    logic        done_r, done_nxt_s;
    logic        busy_r, busy_nxt_s;

    logic        a_signed_s, b_signed_s;
    logic        sign_a_s, sign_b_s;
    logic        zero_op_s;
    logic [15:0] m_a_s, m_b_s;
    logic [31:0] m_q_s;
    logic [63:0] pp_shift_s;
    logic [63:0] p_s;

    // Operand signedness decode and early-zero detection at the start boundary.
    always_comb begin
        a_signed_s = (op_i == OP_MULH) || (op_i == OP_MULHSU);
        b_signed_s = (op_i == OP_MULH);
        sign_a_s   = a_signed_s & rs1_i[31];
        sign_b_s   = b_signed_s & rs2_i[31];
        zero_op_s  = EARLY_ZERO && ((rs1_i == 32'd0) || (rs2_i == 32'd0));
    end

    // Partial-product operand select: cnt[1] picks the A half, cnt[0] the B half.
    always_comb begin
        m_a_s = cnt_r[1] ? a_mag_r[31:16] : a_mag_r[15:0];
        m_b_s = cnt_r[0] ? b_mag_r[31:16] : b_mag_r[15:0];
    end

    mult16 #(
        .AB_SIGNED (1'b0)
    ) u_mult16 (
        .a (m_a_s),
        .b (m_b_s),
        .q (m_q_s)
    );

    // Align the current partial product to its weight in the 64-bit accumulator.
    always_comb begin
        case (cnt_r)
            2'd0:    pp_shift_s = {32'd0, m_q_s};
            2'd1:    pp_shift_s = {16'd0, m_q_s, 16'd0};
            2'd2:    pp_shift_s = {16'd0, m_q_s, 16'd0};
            2'd3:    pp_shift_s = {m_q_s, 32'd0};
            default: pp_shift_s = 64'd0;
        endcase
        p_s = neg64(acc_r, neg_r);
    end

    // Next-state and next-output logic for the IDLE/MUL/FIN sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        acc_nxt_s    = acc_r;
        a_mag_nxt_s  = a_mag_r;
        b_mag_nxt_s  = b_mag_r;
        neg_nxt_s    = neg_r;
        op_nxt_s     = op_r;
        result_nxt_s = result_r;
        done_nxt_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    a_mag_nxt_s = abs32(rs1_i, sign_a_s);
                    b_mag_nxt_s = abs32(rs2_i, sign_b_s);
                    neg_nxt_s   = sign_a_s ^ sign_b_s;
                    op_nxt_s    = op_i;
                    acc_nxt_s   = 64'd0;
                    cnt_nxt_s   = 2'd0;
                    if (zero_op_s) begin
                        state_nxt_s = ST_FIN;
                    end else begin
                        state_nxt_s = ST_MUL;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_nxt_s = acc_r + pp_shift_s;
                cnt_nxt_s = cnt_r + 2'd1;
                if (cnt_r == 2'd3) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_FIN: begin
                if (op_r == OP_MUL) begin
                    result_nxt_s = p_s[31:0];
                end else begin
                    result_nxt_s = p_s[63:32];
                end
                done_nxt_s  = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 2'd0;
                acc_nxt_s   = 64'd0;
            end
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State, datapath and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 2'd0;
            acc_r    <= 64'd0;
            a_mag_r  <= 32'd0;
            b_mag_r  <= 32'd0;
            neg_r    <= 1'b0;
            op_r     <= 2'd0;
            result_r <= 32'd0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            acc_r    <= acc_nxt_s;
            a_mag_r  <= a_mag_nxt_s;
            b_mag_r  <= b_mag_nxt_s;
            neg_r    <= neg_nxt_s;
            op_r     <= op_nxt_s;
            result_r <= result_nxt_s;
            done_r   <= done_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign result_o = result_r;

endmodule

// File: tb/tb_riscv_mul32_seq.sv
// Directed-vector bench for riscv_mul32_seq: table of hand-computed results,
// hand-written handshake/reset/early-zero sequences and a random model check.

module tb_riscv_mul32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1, rs2;
    logic        busy, done;
    logic [31:0] result;
    logic        busy_nz, done_nz;
    logic [31:0] result_nz;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    riscv_mul32_seq #(.EARLY_ZERO(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .rs1_i(rs1), .rs2_i(rs2),
        .busy_o(busy), .done_o(done), .result_o(result)
    );

    riscv_mul32_seq #(.EARLY_ZERO(1'b0)) dut_nz (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .rs1_i(rs1), .rs2_i(rs2),
        .busy_o(busy_nz), .done_o(done_nz), .result_o(result_nz)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // One operation on the main DUT; lat = clocks from start edge to done (0 on timeout).
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(posedge clk);
        #1;
        start = 1'b0; rs1 = $urandom; rs2 = $urandom; op = 2'($urandom_range(0, 3));
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        res = 32'hDEADBEEF;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                res = result;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    logic [31:0] r, r1, r2, ra, rb;
    int lat, lat1, lat2, bc, extra;

    initial begin
        vecs[0]  = '{2'b00, 32'd3,          32'd5,          32'h0000000F};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000};
        vecs[2]  = '{2'b01, 32'h80000000,   32'h80000000,   32'h40000000};
        vecs[3]  = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000};
        vecs[4]  = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE};
        vecs[5]  = '{2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF};
        vecs[6]  = '{2'b10, 32'h00000002,   32'h80000000,   32'h00000001};
        vecs[7]  = '{2'b00, 32'd7,          32'd9,          32'h0000003F};
        vecs[8]  = '{2'b01, 32'h12345678,   32'h00010000,   32'h00001234};
        vecs[9]  = '{2'b11, 32'h00010000,   32'h00010000,   32'h00000001};
        vecs[10] = '{2'b00, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFA};
        vecs[11] = '{2'b01, 32'h80000000,   32'd1,          32'hFFFFFFFF};
        vecs[12] = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'h80000000};

        rst = 1'b1; start = 1'b0; op = 2'b00; rs1 = 32'd0; rs2 = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, bc);
            check($sformatf("vec%0d result", i), r, vecs[i].exp);
            check($sformatf("vec%0d latency", i), lat, 32'd5);
            if (i == 0) check("vec0 busy cycles", bc, 32'd5);
        end

        // Early zero versus full sequence, both DUTs started together.
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs1 = 32'd0; rs2 = 32'h12345678;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat1 = 0; lat2 = 0; r1 = 32'hDEADBEEF; r2 = 32'hDEADBEEF;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done && lat1 == 0) begin lat1 = c; r1 = result; end
            if (done_nz && lat2 == 0) begin lat2 = c; r2 = result_nz; end
            if (lat1 != 0 && lat2 != 0) break;
        end
        check("early zero latency", lat1, 32'd1);
        check("early zero result", r1, 32'd0);
        check("no early zero latency", lat2, 32'd5);
        check("no early zero result", r2, 32'd0);

        // Starts during busy are ignored.
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1 = 32'h00001000; rs2 = 32'h00000010;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0; r = 32'hDEADBEEF;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                start = 1'b1; op = 2'b11; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin lat = c; r = result; break; end
        end
        start = 1'b0;
        check("busy-start latency", lat, 32'd5);
        check("busy-start result", r, 32'h00010000);
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("no queued done", extra, 32'd0);
        check("result held", result, 32'h00010000);

        do_op(2'b11, 32'h00010000, 32'h00010000, ra, lat1, bc);
        do_op(2'b00, 32'h00012345, 32'h00000100, rb, lat2, bc);
        check("b2b first result", ra, 32'h00000001);
        check("b2b second result", rb, 32'h01234500);
        check("b2b second latency", lat2, 32'd5);

        // Asynchronous reset two cycles into an operation.
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1 = 32'h0000FFFF; rs2 = 32'h0000FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset done", {31'd0, done}, 32'd0);
        check("mid reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done || done_nz) extra++;
        end
        check("aborted op no done", extra, 32'd0);
        do_op(2'b00, 32'd7, 32'd9, r, lat, bc);
        check("post reset result", r, 32'h0000003F);
        check("post reset latency", lat, 32'd5);

        for (int i = 0; i < 10000; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom);
            do_op(o, a, b, r, lat, bc);
            check($sformatf("random%0d op%0d %08h*%08h", i, o, a, b), r, model(o, a, b));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/riscv_mul32_seq.md
# riscv_mul32_seq

Sequential 32×32 multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. It time-multiplexes one unsigned `mult16` instance (with `AB_SIGNED` set to 0) over four partial products, accumulates them into a 64-bit result, and applies sign correction. It sits between the execute-stage decode and the `mult16` primitive. It drives the 16-bit operands into that primitive and consumes the 32-bit `q` it produces, returning a 32-bit result to writeback under a start/done handshake.

## Interface
Parameters:
- `EARLY_ZERO`, default 1'b1: when 1, a zero operand bypasses the partial-product sequence.

Ports:
- `clk_i`  in  1  clock; all state changes on rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `start_i`  in  1  request; sampled only when `busy_o`=0
- `op_i`  in  2  operation code: 00=MUL, 01=MULH, 10=MULHSU, 11=MULHU; latched at start
- `rs1_i`  in  32  operand A; latched at start
- `rs2_i`  in  32  operand B; latched at start
- `busy_o`  out  1  high while an operation is in progress
- `done_o`  out  1  one-cycle pulse when `result_o` is valid
- `result_o`  out  32  result; held until the next accepted start's completion

## Operation
- Clock and reset: one clock (`clk_i`); `rst_i` is asynchronous and active-high.

Start latching (when `start_i`=1 and state is IDLE):
- Signedness: A is signed for MULH and MULHSU; B is signed for MULH only.
- Magnitudes: latch |A| and |B| as 32-bit unsigned values. 0x80000000 has magnitude 0x80000000, with no overflow.
- `neg` = signA ^ signB, using only the operands treated as signed.
- Accumulator: clear the 64-bit `acc`; latch `op_i`.

States:
- IDLE: `busy_o`=0.
- MUL: holds a 2-bit step counter `cnt`.
- FIN

Transitions:
- IDLE→MUL (`cnt`=0) on an accepted start.
- IDLE→FIN instead if `EARLY_ZERO`=1 and `rs1_i`==0 or `rs2_i`==0; `acc` stays 0.
- In MUL, `mult16` inputs are selected by `cnt`:
  - `cnt`=0: `acc` += Alo·Blo
  - `cnt`=1: `acc` += (Alo·Bhi)<<16
  - `cnt`=2: `acc` += (Ahi·Blo)<<16
  - `cnt`=3: `acc` += (Ahi·Bhi)<<32
- `cnt` increments each step; at `cnt`=3, go to FIN.
- FIN→IDLE: `p` = `neg` ? (~`acc`+1) : `acc`, computed over 64 bits.
  - `result_o` = `p`[31:0] for MUL, `p`[63:32] otherwise.
  - `done_o`=1 for that one cycle.

Rules:
- Width: `acc` is 64 bits. Partial sums never exceed (2^32−1)^2, so no carry is lost.
- Busy: `busy_o`=1 in MUL and FIN.
- `start_i` while busy: ignored, with no queuing.
- `start_i` in the same cycle as `done_o`: accepted, since the state is already IDLE.
- Operand hold: operands need not be held after the start cycle.
- Reset: reset at any time, including mid-operation, forces IDLE, `acc`=0, `cnt`=0, `result_o`=0, `done_o`=0, `busy_o`=0. An aborted operation produces no `done_o`.

## Timing
- Latency, full path: start sampled at edge E0; partial products accumulate at E1–E4; `result_o` and `done_o` are registered at E5. `done_o` is high in the cycle after E5, i.e. 5 clocks of latency.
- Latency, early-zero path: `done_o` is high after E1, i.e. 1 clock of latency.
- Throughput: back-to-back operations are possible with start asserted in the `done_o` cycle, giving one result per 5 clocks.
- Combinational paths: the `mult16` path is purely combinational within one cycle. The only register in that path is `acc`.
- Output registering: `done_o`, `busy_o` and `result_o` are registered, with no combinational path from inputs.

## Test plan
- MUL 3×5 → `done_o` 5 clocks after start, `result_o`=0x0000000F; `busy_o` high for exactly 5 cycles.
- Signed corner cases:
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MUL 0x80000000×0xFFFFFFFF → 0x80000000.
- Unsigned and mixed:
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MULHSU 0x00000002×0x80000000 → 0x00000001.
- Early zero (`EARLY_ZERO`=1): MULH 0×0x12345678 → `done_o` 1 clock after start, `result_o`=0. With `EARLY_ZERO`=0 the same operation takes 5 clocks and gives the same result.
- Handshake: `start_i` pulses during busy with different operands are ignored. A new start in the `done_o` cycle is accepted and the second result is correct. `result_o` holds its value between operations.
- Reset mid-operation: assert `rst_i` asynchronously 2 cycles after start.
  - All outputs go to 0 immediately and no `done_o` follows.
  - The next operation, MUL 7×9, returns 0x0000003F.
- Random regression: 10k random operand/op pairs checked against a 64-bit behavioural model.
